// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_rx_fifo                                                     |
// | Brief    : PS/2 device-to-host receiver with deglitch, frame checks and a  |
// |            show-ahead FIFO of tagged scan codes, all in the clk_50 domain. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit ERR_PUSH       = 1'b1
) (
  input  logic                             clk_50,
  input  logic                             rst,
  input  logic                             key_clock,
  input  logic                             key_data,
  output logic [7:0]                       rx_data,
  output logic                             rx_err,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow,
  input  logic                             overflow_clr,
  output logic                             frame_abort,
  output logic [7:0]                       last_code
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic          kc_s1_q, kc_s2_q, kd_s1_q, kd_s2_q;
  logic          kc_f_q, kc_f_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall_w;

  state_t        state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic          push_q, push_d;
  logic          push_err_q, push_err_d;
  logic          abort_q, abort_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    last_code_q;
  logic          en_w, full_w, do_push_w, do_pop_w;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      {kc_s1_q, kc_s2_q, kd_s1_q, kd_s2_q} <= 4'hF;
    end else begin
      kc_s1_q <= key_clock;
      kc_s2_q <= kc_s1_q;
      kd_s1_q <= key_data;
      kd_s2_q <= kd_s1_q;
    end
  end

  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    kc_f_d    = kc_f_q;
    flt_cnt_d = '0;
    fall_w    = 1'b0;
    if (kc_s2_q != kc_f_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        kc_f_d = kc_s2_q;
        fall_w = kc_f_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    push_d     = 1'b0;
    push_err_d = push_err_q;
    abort_d    = 1'b0;
    to_cnt_d   = '0;
    if (state_q != ST_IDLE && !fall_w) to_cnt_d = to_cnt_q + TW'(1);
    if (fall_w) begin
      case (state_q)
        ST_IDLE: begin
          if (!kd_s2_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            abort_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {kd_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_err_d = ~(^shift_q ^ kd_s2_q);
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          push_d     = 1'b1;
          push_err_d = par_err_q | ~kd_s2_q;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_cnt_d == TW'(TIMEOUT_CYCLES)) begin
      state_d  = ST_IDLE;
      abort_d  = 1'b1;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      kc_f_q     <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_err_q  <= 1'b0;
      push_q     <= 1'b0;
      push_err_q <= 1'b0;
      abort_q    <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      kc_f_q     <= kc_f_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      push_q     <= push_d;
      push_err_q <= push_err_d;
      abort_q    <= abort_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // shift_q stays stable through the push cycle: the next frame needs further falls.
  assign en_w      = push_q & (ERR_PUSH | ~push_err_q);
  assign full_w    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop_w  = rx_valid & rx_ready;
  assign do_push_w = en_w & (~full_w | do_pop_w);

  always_ff @(posedge clk_50) begin
    if (do_push_w) mem_q[wr_ptr_q] <= {push_err_q, shift_q};
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_code_q <= 8'd0;
    end else begin
      if (do_push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push_w && !do_pop_w)      count_q <= count_q + CW'(1);
      else if (!do_push_w && do_pop_w) count_q <= count_q - CW'(1);
      if (en_w && full_w && !do_pop_w) overflow_q <= 1'b1;
      else if (overflow_clr)           overflow_q <= 1'b0;
      if (push_q && !push_err_q)       last_code_q <= shift_q;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
  assign rx_err      = rx_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_abort = abort_q;
  assign last_code   = last_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_rx_fifo                                                  |
// | Brief    : Directed plus random PS/2 frames against a queue-based model,   |
// |            one DUT pushing errored frames and one discarding them.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int FLT   = 8;
  localparam int TO    = 400;
  localparam int HP    = 40;

  logic       clk = 1'b0, rst = 1'b1, kc = 1'b1, kd = 1'b1;
  logic       rdy1 = 1'b0, rdy0 = 1'b0, oclr = 1'b0;
  logic [7:0] d1, d0, l1, l0;
  logic       e1, e0, v1, v0, o1, o0, a1, a0;
  logic [3:0] c1, c0;

  int total = 0, bad = 0;
  int ab1 = 0, ab0 = 0;

  logic [8:0] q1[$], q0[$];
  bit         ovf1 = 0, ovf0 = 0;
  logic [7:0] lc = 8'd0;

  always #10 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO), .ERR_PUSH(1'b1)) dut (
    .clk_50(clk), .rst(rst), .key_clock(kc), .key_data(kd),
    .rx_data(d1), .rx_err(e1), .rx_valid(v1), .rx_ready(rdy1), .fifo_count(c1),
    .overflow(o1), .overflow_clr(oclr), .frame_abort(a1), .last_code(l1));

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO), .ERR_PUSH(1'b0)) dut0 (
    .clk_50(clk), .rst(rst), .key_clock(kc), .key_data(kd),
    .rx_data(d0), .rx_err(e0), .rx_valid(v0), .rx_ready(rdy0), .fifo_count(c0),
    .overflow(o0), .overflow_clr(oclr), .frame_abort(a0), .last_code(l0));

  always @(negedge clk) begin
    if (a1 === 1'b1) ab1++;
    if (a0 === 1'b1) ab0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame either lands, is dropped for lack of space, or is discarded.
  task automatic m_push(input logic [7:0] d, input bit err);
    if (!err) lc = d;
    if (q1.size() < DEPTH) q1.push_back({err, d});
    else ovf1 = 1;
    if (!err) begin
      if (q0.size() < DEPTH) q0.push_back({1'b0, d});
      else ovf0 = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid1"}, v1, q1.size() != 0);
    chk({tag, ".count1"}, c1, q1.size());
    if (q1.size() != 0) begin
      chk({tag, ".data1"}, d1, q1[0][7:0]);
      chk({tag, ".err1"},  e1, q1[0][8]);
    end
    chk({tag, ".ovf1"},  o1, ovf1);
    chk({tag, ".last1"}, l1, lc);
    chk({tag, ".valid0"}, v0, q0.size() != 0);
    chk({tag, ".count0"}, c0, q0.size());
    if (q0.size() != 0) chk({tag, ".data0"}, d0, q0[0][7:0]);
    chk({tag, ".ovf0"},  o0, ovf0);
    chk({tag, ".last0"}, l0, lc);
  endtask

  task automatic pop1(input string tag);
    chk({tag, ".hd1"}, {e1, d1}, q1[0]);
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    void'(q1.pop_front());
  endtask

  task automatic pop0(input string tag);
    chk({tag, ".hd0"}, d0, q0[0][7:0]);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    void'(q0.pop_front());
  endtask

  task automatic drain(input string tag);
    while (q1.size() != 0) pop1(tag);
    while (q0.size() != 0) pop0(tag);
  endtask

  // pp: raise rdy1 for exactly the cycle the stop-bit push reaches the FIFO.
  task automatic send_bit(input logic b, input bit glitch, input bit pp);
    kd = b;
    repeat (HP) @(negedge clk);
    kc = 1'b0;
    if (pp) begin
      repeat (FLT + 2) @(negedge clk);
      chk("pp.head", d1, q1[0][7:0]);
      rdy1 = 1'b1;
      @(negedge clk);
      rdy1 = 1'b0;
      void'(q1.pop_front());
      repeat (HP - FLT - 3) @(negedge clk);
    end else begin
      repeat (HP) @(negedge clk);
    end
    kc = 1'b1;
    if (glitch) begin
      repeat (HP / 2) @(negedge clk);
      kc = 1'b0;
      repeat (3) @(negedge clk);
      kc = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit perr, input bit serr,
                            input bit glitch, input bit pp);
    logic [10:0] bits;
    bits = {~serr, ~^d ^ perr, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && i == 4, pp && i == 10);
    repeat (HP) @(negedge clk);
    m_push(d, perr | serr);
  endtask

  task automatic reset_model();
    q1.delete(); q0.delete();
    ovf1 = 0; ovf0 = 0; lc = 8'd0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit pe, se;
    repeat (3) @(negedge clk);
    chk("rst.valid", v1, 1'b0);
    chk("rst.count", c1, 4'd0);
    chk("rst.data",  d1, 8'd0);
    chk("rst.err",   e1, 1'b0);
    chk("rst.ovf",   o1, 1'b0);
    chk("rst.abort", a1, 1'b0);
    chk("rst.last",  l1, 8'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    rdy1 = 1'b1; rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    rdy1 = 1'b0; rdy0 = 1'b0;
    check_all("empty_ready");

    send_frame(8'h1C, 0, 0, 0, 0);
    check_all("clean");
    chk("clean.data_const", d1, 8'h1C);
    chk("clean.last_const", l1, 8'h1C);
    drain("clean");
    check_all("clean_pop");

    send_frame(8'h1C, 1, 0, 0, 0);
    check_all("perr");
    chk("perr.err_const", e1, 1'b1);
    chk("perr.count0",    c0, 4'd0);
    drain("perr");

    send_frame(8'hF0, 0, 0, 1, 0);
    check_all("glitch");
    chk("glitch.data_const", d1, 8'hF0);
    drain("glitch");

    ab1 = 0; ab0 = 0;
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0, 0);
    repeat (3 * TO) @(negedge clk);
    chk("timeout.aborts1", ab1, 1);
    chk("timeout.aborts0", ab0, 1);
    check_all("timeout");
    send_frame(8'h5A, 0, 0, 0, 0);
    check_all("after_timeout");
    drain("after_timeout");

    ab1 = 0;
    send_bit(1'b1, 0, 0);
    repeat (HP) @(negedge clk);
    chk("badstart.aborts", ab1, 1);
    check_all("badstart");

    for (int n = 0; n < 6; n++) begin
      rd = 8'($urandom_range(0, 255));
      pe = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 3) == 0);
      send_frame(rd, pe, se, 0, 0);
      check_all("rand");
      if ($urandom_range(0, 1) == 1 && q1.size() != 0) pop1("rand");
      if ($urandom_range(0, 1) == 1 && q0.size() != 0) pop0("rand");
    end
    drain("rand");

    for (int n = 1; n <= 9; n++) send_frame(8'(n), 0, 0, 0, 0);
    check_all("overflow");
    chk("overflow.count_const", c1, 4'd8);
    chk("overflow.flag_const",  o1, 1'b1);
    oclr = 1'b1;
    @(negedge clk);
    oclr = 1'b0;
    ovf1 = 0; ovf0 = 0;
    check_all("ovf_clr");

    send_frame(8'h33, 0, 0, 0, 1);
    check_all("pushpop_full");
    chk("pushpop.ovf_const", o1, 1'b0);
    drain("pushpop");
    check_all("pushpop_drained");

    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 0);
    send_frame(8'h44, 0, 0, 0, 0);
    kd = 1'b0; kc = 1'b1;
    for (int i = 0; i < 2; i++) send_bit(1'b1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_all("midreset");
    repeat (HP) @(negedge clk);
    send_frame(8'h77, 0, 0, 0, 0);
    check_all("after_reset");
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
